// File: rtl/reg_file_sb.sv
// Register file with asynchronous zeroing reset, NRD combinational read ports and a per-register busy scoreboard.
// Latency: reads are combinational; writes and busy updates land at posedge (optionally bypassed to reads).
// Backpressure: none; every write/alloc/flush is accepted in the cycle it is presented.
module reg_file_sb #(
    parameter int XLEN    = 32,
    parameter int NREGS   = 32,
    parameter int NRD     = 2,
    parameter int BYPASS  = 1,
    parameter int ZERO_R0 = 1,
    localparam int AW     = (NREGS > 1) ? $clog2(NREGS) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                w_en,
    input  logic [AW-1:0]       w_adr,
    input  logic [XLEN-1:0]     w_data,
    input  logic                alloc_en,
    input  logic [AW-1:0]       alloc_adr,
    input  logic                flush,
    input  logic [NRD*AW-1:0]   rd_adr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]      rd_busy
);

    logic [XLEN-1:0]  regs [NREGS];
    logic [NREGS-1:0] busy;

    // Backing entry exists and is not the hardwired zero register.
    function automatic logic adr_ok(input logic [AW-1:0] a);
        return (32'(a) < 32'(NREGS)) && !((ZERO_R0 != 0) && (a == '0));
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
            busy <= '0;
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                if (w_en && (w_adr == AW'(i)) && adr_ok(AW'(i))) begin
                    regs[i] <= w_data;
                end
                // A newly issued producer owns the register even if its old value retires now.
                if (flush) begin
                    busy[i] <= 1'b0;
                end else if (alloc_en && (alloc_adr == AW'(i)) && adr_ok(AW'(i))) begin
                    busy[i] <= 1'b1;
                end else if (w_en && (w_adr == AW'(i)) && adr_ok(AW'(i))) begin
                    busy[i] <= 1'b0;
                end
            end
        end
    end

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0] a;
        logic          ok;
        logic          byp;

        assign a   = rd_adr[k*AW +: AW];
        assign ok  = adr_ok(a);
        // Held off during reset so outputs read zero while rst_n is low.
        assign byp = (BYPASS != 0) && rst_n && w_en && (w_adr == a);

        assign rd_data[k*XLEN +: XLEN] = !ok ? '0 : (byp ? w_data : regs[a]);
        assign rd_busy[k]              = ok && !byp && busy[a];
    end

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed bench for reg_file_sb: default build, a no-bypass build and a 24x16, 3-port build.
module tb_reg_file_sb;

    logic        clk;
    logic        rst_n;
    logic        w_en;
    logic [4:0]  w_adr;
    logic [31:0] w_data;
    logic        alloc_en;
    logic [4:0]  alloc_adr;
    logic        flush;
    logic [9:0]  rd_adr;
    logic [63:0] rd_data;
    logic [1:0]  rd_busy;
    logic [63:0] nb_rd_data;
    logic [1:0]  nb_rd_busy;

    logic        s_w_en;
    logic [4:0]  s_w_adr;
    logic [15:0] s_w_data;
    logic        s_alloc_en;
    logic [4:0]  s_alloc_adr;
    logic        s_flush;
    logic [14:0] s_rd_adr;
    logic [47:0] s_rd_data;
    logic [2:0]  s_rd_busy;

    int checks = 0;
    int fails  = 0;

    reg_file_sb dut (
        .clk(clk), .rst_n(rst_n), .w_en(w_en), .w_adr(w_adr), .w_data(w_data),
        .alloc_en(alloc_en), .alloc_adr(alloc_adr), .flush(flush),
        .rd_adr(rd_adr), .rd_data(rd_data), .rd_busy(rd_busy)
    );

    reg_file_sb #(.BYPASS(0)) dut_nb (
        .clk(clk), .rst_n(rst_n), .w_en(w_en), .w_adr(w_adr), .w_data(w_data),
        .alloc_en(alloc_en), .alloc_adr(alloc_adr), .flush(flush),
        .rd_adr(rd_adr), .rd_data(nb_rd_data), .rd_busy(nb_rd_busy)
    );

    reg_file_sb #(.XLEN(16), .NREGS(24), .NRD(3)) dut_s (
        .clk(clk), .rst_n(rst_n), .w_en(s_w_en), .w_adr(s_w_adr), .w_data(s_w_data),
        .alloc_en(s_alloc_en), .alloc_adr(s_alloc_adr), .flush(s_flush),
        .rd_adr(s_rd_adr), .rd_data(s_rd_data), .rd_busy(s_rd_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; w_en = 1'b0; w_adr = '0; w_data = '0;
        alloc_en = 1'b0; alloc_adr = '0; flush = 1'b0; rd_adr = '0;
        s_w_en = 1'b0; s_w_adr = '0; s_w_data = '0;
        s_alloc_en = 1'b0; s_alloc_adr = '0; s_flush = 1'b0; s_rd_adr = '0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        for (int i = 1; i < 32; i++) begin
            rd_adr = {5'(i), 5'(i)};
            #1;
            chk("reset_data", rd_data, 64'h0);
            chk("reset_busy", {62'h0, rd_busy}, 64'h0);
        end
        s_rd_adr = {5'd23, 5'd1, 5'd0};
        #1;
        chk("s_reset_data", {16'h0, s_rd_data}, 64'h0);

        // Reset asserted while a write to x5 is presented.
        w_en = 1'b1; w_adr = 5'd5; w_data = 32'hDEADBEEF; rd_adr = {5'd5, 5'd5};
        rst_n = 1'b0;
        #1;
        chk("reset_no_bypass", rd_data, 64'h0);
        tick();
        rst_n = 1'b1; w_en = 1'b0;
        #1;
        chk("reset_mid_write", rd_data, 64'h0);

        w_en = 1'b1; w_adr = 5'd0; w_data = 32'h12345678;
        tick();
        w_en = 1'b0; rd_adr = {5'd0, 5'd0};
        #1;
        chk("x0_zero", rd_data, 64'h0);

        w_en = 1'b1; w_adr = 5'd31; w_data = 32'hA5A5A5A5;
        tick();
        w_en = 1'b0; rd_adr = {5'd31, 5'd31};
        #1;
        chk("x31_both_ports", rd_data, 64'hA5A5A5A5_A5A5A5A5);
        chk("x31_nb", nb_rd_data, 64'hA5A5A5A5_A5A5A5A5);

        w_en = 1'b1; w_adr = 5'd7; w_data = 32'h11111111;
        tick();
        rd_adr = {5'd31, 5'd7}; w_adr = 5'd7; w_data = 32'hCAFEF00D;
        #1;
        chk("bypass_same_cycle", rd_data, 64'hA5A5A5A5_CAFEF00D);
        chk("nobypass_old", nb_rd_data, 64'hA5A5A5A5_11111111);
        tick();
        w_en = 1'b0;
        #1;
        chk("nobypass_new", nb_rd_data, 64'hA5A5A5A5_CAFEF00D);

        alloc_en = 1'b1; alloc_adr = 5'd3;
        tick();
        alloc_en = 1'b0; rd_adr = {5'd3, 5'd3};
        #1;
        chk("alloc_busy", {62'h0, rd_busy}, 64'h3);
        w_en = 1'b1; w_adr = 5'd3; w_data = 32'h55;
        #1;
        chk("write_bypass_busy", {62'h0, rd_busy}, 64'h0);
        chk("write_bypass_data", rd_data, 64'h55_00000055);
        chk("nb_busy_in_write", {62'h0, nb_rd_busy}, 64'h3);
        tick();
        w_en = 1'b0;
        #1;
        chk("write_clears_busy", {62'h0, rd_busy}, 64'h0);
        chk("write_data_x3", rd_data, 64'h55_00000055);
        chk("nb_busy_after", {62'h0, nb_rd_busy}, 64'h0);

        alloc_en = 1'b1; alloc_adr = 5'd4; w_en = 1'b1; w_adr = 5'd4; w_data = 32'h99;
        tick();
        alloc_en = 1'b0; w_en = 1'b0; rd_adr = {5'd4, 5'd4};
        #1;
        chk("alloc_beats_write_data", rd_data, 64'h99_00000099);
        chk("alloc_beats_write_busy", {62'h0, rd_busy}, 64'h3);

        alloc_en = 1'b1; alloc_adr = 5'd5;
        tick();
        alloc_adr = 5'd6;
        tick();
        alloc_adr = 5'd6;
        tick();
        alloc_en = 1'b0; rd_adr = {5'd6, 5'd5};
        #1;
        chk("busy_x5_x6", {62'h0, rd_busy}, 64'h3);
        flush = 1'b1; alloc_en = 1'b1; alloc_adr = 5'd8;
        tick();
        flush = 1'b0; alloc_en = 1'b0; rd_adr = {5'd5, 5'd4};
        #1;
        chk("flush_x4_x5", {62'h0, rd_busy}, 64'h0);
        rd_adr = {5'd8, 5'd6};
        #1;
        chk("flush_x6_x8", {62'h0, rd_busy}, 64'h0);

        alloc_en = 1'b1; alloc_adr = 5'd0;
        tick();
        alloc_en = 1'b0; rd_adr = {5'd0, 5'd0};
        #1;
        chk("x0_never_busy", {62'h0, rd_busy}, 64'h0);

        s_w_en = 1'b1; s_w_adr = 5'd23; s_w_data = 16'hBEEF;
        tick();
        s_w_en = 1'b0; s_rd_adr = {5'd23, 5'd23, 5'd23};
        #1;
        chk("s_x23_data", {16'h0, s_rd_data}, 64'h0000_BEEF_BEEF_BEEF);
        chk("s_x23_busy", {61'h0, s_rd_busy}, 64'h0);
        s_w_en = 1'b1; s_w_adr = 5'd25; s_w_data = 16'h1234;
        s_alloc_en = 1'b1; s_alloc_adr = 5'd25; s_rd_adr = {5'd25, 5'd23, 5'd25};
        #1;
        chk("s_oob_no_bypass", {16'h0, s_rd_data}, 64'h0000_0000_BEEF_0000);
        tick();
        s_w_en = 1'b0; s_alloc_en = 1'b0;
        #1;
        chk("s_oob_data", {16'h0, s_rd_data}, 64'h0000_0000_BEEF_0000);
        chk("s_oob_busy", {61'h0, s_rd_busy}, 64'h0);
        s_alloc_en = 1'b1; s_alloc_adr = 5'd23;
        tick();
        s_alloc_en = 1'b0;
        #1;
        chk("s_x23_alloc", {61'h0, s_rd_busy}, 64'h2);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
